// File: rtl/mux_scan_nt1_if.sv
// Channel bus for mux_scan_nt1; ch_mask is present only when MUX_SCAN_MASK_EN is defined.
// Stimulus side drives data/controls; the mux drives o, cur_sel, o_valid and wrap.
interface mux_scan_nt1_if #(
  parameter int WIDTH = 5,
  parameter int CH    = 4,
  parameter int SEL_W = 2
);
  logic [CH*WIDTH-1:0] din;
  logic [SEL_W-1:0]    sel;
  logic                mode;
  logic                en;
  logic [WIDTH-1:0]    o;
  logic [SEL_W-1:0]    cur_sel;
  logic                o_valid;
  logic                wrap;
`ifdef MUX_SCAN_MASK_EN
  logic [CH-1:0]       ch_mask;

  modport master (output din, sel, mode, en, ch_mask,
                  input  o, cur_sel, o_valid, wrap);
  modport slave  (input  din, sel, mode, en, ch_mask,
                  output o, cur_sel, o_valid, wrap);
`else
  modport master (output din, sel, mode, en,
                  input  o, cur_sel, o_valid, wrap);
  modport slave  (input  din, sel, mode, en,
                  output o, cur_sel, o_valid, wrap);
`endif
endinterface

// File: rtl/mux_scan_nt1.sv
// N:1 registered mux, direct select or round-robin scan; MUX_SCAN_MASK_EN adds a channel mask for scan.
// Latency 1 cycle; no backpressure, en=0 freezes all state.
module mux_scan_nt1 #(
  parameter int WIDTH    = 5,
  parameter int CH       = 4,
  parameter int SEL_W    = 2,
  parameter int SCAN_DIV = 3
) (
  input  logic          clk,
  input  logic          rst,
  mux_scan_nt1_if.slave bus
);

  localparam logic [0:0] DIRECT = 1'b0;
  localparam logic [0:0] SCAN   = 1'b1;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [0:0]       st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SEL_W-1:0] ptr, ptr_n, cur_n;
  logic [WIDTH-1:0] o_n;
  logic             v_n, wrap_n;

  logic             sel_ok, live, adv_wrap;
  logic [SEL_W-1:0] load_ptr, adv_ptr;

  function automatic logic [WIDTH-1:0] chan(input logic [CH*WIDTH-1:0] d, input int k);
    chan = '0;
    for (int i = 0; i < CH; i++)
      if (i == k) chan = d[i*WIDTH +: WIDTH];
  endfunction

  assign sel_ok = int'(bus.sel) < CH;

`ifdef MUX_SCAN_MASK_EN
  logic             any_en;
  logic             found;
  logic [SEL_W-1:0] low;

  // Next enabled channel above ptr (wrapping), and lowest enabled for entry loads.
  always_comb begin
    any_en   = |bus.ch_mask;
    found    = 1'b0;
    adv_ptr  = ptr;
    adv_wrap = 1'b0;
    low      = ptr;
    for (int k = 1; k <= CH; k++) begin
      if (!found && bus.ch_mask[(int'(ptr) + k) % CH]) begin
        found    = 1'b1;
        adv_ptr  = SEL_W'((int'(ptr) + k) % CH);
        adv_wrap = ((int'(ptr) + k) % CH) <= int'(ptr);
      end
    end
    for (int k = CH - 1; k >= 0; k--)
      if (bus.ch_mask[k]) low = SEL_W'(k);
    live     = any_en;
    load_ptr = (sel_ok && bus.ch_mask[bus.sel]) ? bus.sel : low;
  end
`else
  always_comb begin
    live     = 1'b1;
    load_ptr = sel_ok ? bus.sel : '0;
    adv_wrap = int'(ptr) == CH - 1;
    adv_ptr  = adv_wrap ? '0 : ptr + SEL_W'(1);
  end
`endif

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    ptr_n  = ptr;
    cur_n  = bus.cur_sel;
    o_n    = bus.o;
    v_n    = bus.o_valid;
    wrap_n = 1'b0;
    if (bus.en) begin
      if (!bus.mode) begin
        st_n  = DIRECT;
        cnt_n = '0;
        cur_n = bus.sel;
        v_n   = sel_ok;
        o_n   = sel_ok ? chan(bus.din, int'(bus.sel)) : '0;
      end else begin
        st_n = SCAN;
        if (st == DIRECT) begin
          ptr_n = load_ptr;
          cnt_n = '0;
        end else if (!live) begin
          cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_n  = '0;
          ptr_n  = adv_ptr;
          wrap_n = adv_wrap;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
        // Data is re-registered every enabled cycle so mid-dwell input changes show up.
        cur_n = ptr_n;
        v_n   = live;
        o_n   = live ? chan(bus.din, int'(ptr_n)) : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= DIRECT;
      cnt         <= '0;
      ptr         <= '0;
      bus.o       <= '0;
      bus.cur_sel <= '0;
      bus.o_valid <= 1'b0;
      bus.wrap    <= 1'b0;
    end else begin
      st          <= st_n;
      cnt         <= cnt_n;
      ptr         <= ptr_n;
      bus.o       <= o_n;
      bus.cur_sel <= cur_n;
      bus.o_valid <= v_n;
      bus.wrap    <= wrap_n;
    end
  end

endmodule
